// File: rtl/dispatch_pkg.sv
// Types shared by rename, dispatch and the issue queues.
package processor_help;

  localparam int ROB_DEPTH_DEFAULT = 32;
  localparam int ROB_INDEX_W       = $clog2(ROB_DEPTH_DEFAULT);

  typedef logic [ROB_INDEX_W-1:0] RobIndex;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_MEM    = 2'd1,
    FU_BRANCH = 2'd2
  } FuClass;

  typedef struct packed {
    FuClass      fu_class;
    logic [6:0]  opcode;
    logic [5:0]  dst_preg;
    logic [5:0]  src1_preg;
    logic [5:0]  src2_preg;
    logic [31:0] imm;
    logic [31:0] pc;
  } RenamedInstruction;

  typedef struct packed {
    RenamedInstruction instr;
    RobIndex           rob_index;
  } DispatchPayload;

  // One-hot issue-queue select, ordered {branch, mem, alu}.
  function automatic logic [2:0] fu_select(input FuClass fu);
    logic [2:0] sel;
    case (fu)
      FU_ALU:    sel = 3'b001;
      FU_MEM:    sel = 3'b010;
      FU_BRANCH: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dispatch_if.sv
// Rename, ROB and issue-queue handshakes of the dispatch stage.
interface dispatch_if;
  import processor_help::*;

  logic              rename_ready_out;
  logic              rename_valid_in;
  RenamedInstruction rename_payload_in;
  logic              rob_write_valid_out;
  RobIndex           rob_write_index_out;
  RenamedInstruction rob_write_payload_out;
  logic              rob_retire_valid_in;
  logic              alu_iq_ready_in;
  logic              mem_iq_ready_in;
  logic              branch_iq_ready_in;
  logic              alu_iq_valid_out;
  logic              mem_iq_valid_out;
  logic              branch_iq_valid_out;
  DispatchPayload    iq_payload_out;
  logic              flush_in;

  modport slave (
    output rename_ready_out, rob_write_valid_out, rob_write_index_out,
           rob_write_payload_out, alu_iq_valid_out, mem_iq_valid_out,
           branch_iq_valid_out, iq_payload_out,
    input  rename_valid_in, rename_payload_in, rob_retire_valid_in,
           alu_iq_ready_in, mem_iq_ready_in, branch_iq_ready_in, flush_in
  );

  modport master (
    input  rename_ready_out, rob_write_valid_out, rob_write_index_out,
           rob_write_payload_out, alu_iq_valid_out, mem_iq_valid_out,
           branch_iq_valid_out, iq_payload_out,
    output rename_valid_in, rename_payload_in, rob_retire_valid_in,
           alu_iq_ready_in, mem_iq_ready_in, branch_iq_ready_in, flush_in
  );
endinterface

// File: rtl/dispatch_checker.sv
// Simulation-only protocol checks for the dispatch stage.
module dispatch_checker #(
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  input logic             retire,
  input logic [CNT_W-1:0] rob_count
);
  // A retire must never arrive while the ROB is empty.
  always @(posedge clk) begin
    if (rst_n && !flush && retire) begin
      assert (rob_count != '0) else $error("dispatch: retire with empty ROB");
    end
  end
endmodule

// File: rtl/dispatch_fifo.sv
// Small ready/valid FIFO with synchronous active-low reset and flush.
module dispatch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // Handshake decode; ready comes from registered occupancy only.
  always_comb begin
    push_ready = rst_n && (count_r < CNT_FULL);
    pop_valid  = (count_r != '0);
    pop_data   = mem_r[head_r];
    push_s     = push_valid && push_ready && !flush;
    pop_s      = pop_valid && pop_ready && !flush;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) tail_r <= next_ptr(tail_r);
      if (pop_s)  head_r <= next_ptr(head_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is write-only on push; contents are meaningless when empty.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[tail_r] <= push_data;
  end
endmodule

// File: rtl/dispatch.sv
// Dispatch stage: buffers renamed instructions, allocates ROB slots in order
// and routes each instruction to its issue queue.
module dispatch
  import processor_help::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
  input logic       clk_in,
  input logic       rst_in,
  dispatch_if.slave dif
);
  localparam int TAIL_W = $clog2(ROB_DEPTH);
  localparam int CNT_W  = $clog2(ROB_DEPTH + 1);
  localparam logic [CNT_W-1:0]  ROB_FULL = CNT_W'(ROB_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TAIL_W-1:0] TAIL_ONE = TAIL_W'(1);

  logic [TAIL_W-1:0] rob_tail_r;
  logic [CNT_W-1:0]  rob_count_r;
  logic              head_valid_s;
  RenamedInstruction head_s;
  RobIndex           rob_index_s;
  logic [2:0]        target_s;
  logic              target_ready_s;
  logic              rob_space_s;
  logic              issue_ok_s;
  logic              fire_s;
  logic              retire_s;

  dispatch_fifo #(
    .DEPTH (2),
    .T     (RenamedInstruction)
  ) u_fifo (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .flush      (dif.flush_in),
    .push_valid (dif.rename_valid_in),
    .push_ready (dif.rename_ready_out),
    .push_data  (dif.rename_payload_in),
    .pop_valid  (head_valid_s),
    .pop_ready  (fire_s),
    .pop_data   (head_s)
  );

  dispatch_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .flush     (dif.flush_in),
    .retire    (dif.rob_retire_valid_in),
    .rob_count (rob_count_r)
  );

  // Route the head to its queue; valid never looks at any queue ready.
  always_comb begin
    rob_index_s    = RobIndex'(rob_tail_r);
    rob_space_s    = (rob_count_r < ROB_FULL);
    issue_ok_s     = rst_in && head_valid_s && rob_space_s && !dif.flush_in;
    target_s       = fu_select(head_s.fu_class);
    target_ready_s = |(target_s & {dif.branch_iq_ready_in, dif.mem_iq_ready_in,
                                   dif.alu_iq_ready_in});
    fire_s         = issue_ok_s && target_ready_s;
    retire_s       = dif.rob_retire_valid_in && (rob_count_r != '0);

    dif.alu_iq_valid_out    = issue_ok_s && target_s[0];
    dif.mem_iq_valid_out    = issue_ok_s && target_s[1];
    dif.branch_iq_valid_out = issue_ok_s && target_s[2];
    dif.rob_write_valid_out = fire_s;

    if (rst_in) begin
      dif.rob_write_index_out   = rob_index_s;
      dif.rob_write_payload_out = head_s;
    end else begin
      dif.rob_write_index_out   = '0;
      dif.rob_write_payload_out = '0;
    end

    // Head and tail only move on fire, so the payload holds under backpressure.
    if (rst_in && head_valid_s) begin
      dif.iq_payload_out.instr     = head_s;
      dif.iq_payload_out.rob_index = rob_index_s;
    end else begin
      dif.iq_payload_out = '0;
    end
  end

  // ROB tail and occupancy; reset and flush both empty the ROB.
  always_ff @(posedge clk_in) begin
    if (!rst_in || dif.flush_in) begin
      rob_tail_r  <= '0;
      rob_count_r <= '0;
    end else begin
      if (fire_s) rob_tail_r <= rob_tail_r + TAIL_ONE;
      case ({fire_s, retire_s})
        2'b10:   rob_count_r <= rob_count_r + CNT_ONE;
        2'b01:   rob_count_r <= rob_count_r - CNT_ONE;
        default: rob_count_r <= rob_count_r;
      endcase
    end
  end
endmodule

// File: tb/tb_dispatch.sv
// Directed scoreboard bench for dispatch (ROB_DEPTH 32 and 4 instances).
module tb_dispatch;
  import processor_help::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   fires32 = 0;
  int   fires4 = 0;
  logic acc32 = 1'b0;
  logic acc4 = 1'b0;
  logic [4:0] tail32 = 5'd0;
  logic [1:0] tail4 = 2'd0;
  DispatchPayload q32[$];
  DispatchPayload q4[$];

  dispatch_if d32();
  dispatch_if d4();

  dispatch #(.ROB_DEPTH(32)) dut  (.clk_in(clk), .rst_in(rst_n), .dif(d32));
  dispatch #(.ROB_DEPTH(4))  dut4 (.clk_in(clk), .rst_in(rst_n), .dif(d4));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(input FuClass fu);
    case (fu)
      FU_ALU:    return 3'b001;
      FU_MEM:    return 3'b010;
      FU_BRANCH: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic RenamedInstruction mk(input FuClass fu, input int n);
    RenamedInstruction r;
    r.fu_class  = fu;
    r.opcode    = 7'(n * 3 + 1);
    r.dst_preg  = 6'(n);
    r.src1_preg = 6'(n + 1);
    r.src2_preg = 6'(n + 2);
    r.imm       = 32'(n) * 32'h0101_0101;
    r.pc        = 32'h8000_0000 + 32'(n * 4);
    return r;
  endfunction

  task automatic mon_one(input bit use4, input logic [2:0] v, input logic [2:0] r,
                         input logic wr_v, input DispatchPayload iqp,
                         input RobIndex wi, input RenamedInstruction wp);
    logic f;
    DispatchPayload e;
    f = |(v & r);
    check(use4 ? "rob_wr_strobe4" : "rob_wr_strobe32", 128'(wr_v), 128'(f));
    if (f) begin
      if (use4) fires4++; else fires32++;
      check(use4 ? "sb_nonempty4" : "sb_nonempty32",
            128'(use4 ? (q4.size() != 0) : (q32.size() != 0)), 128'(1));
      if ((use4 && q4.size() != 0) || (!use4 && q32.size() != 0)) begin
        e = use4 ? q4.pop_front() : q32.pop_front();
        check("iq_payload", 128'(iqp), 128'(e));
        check("rob_wr_index", 128'(wi), 128'(e.rob_index));
        check("rob_wr_payload", 128'(wp), 128'(e.instr));
        check("iq_target", 128'(v), 128'(exp_sel(e.instr.fu_class)));
      end
    end
  endtask

  // One clock: observe at negedge, record enqueues, return 1 after posedge.
  task automatic step();
    DispatchPayload e;
    @(negedge clk);
    mon_one(1'b0, {d32.branch_iq_valid_out, d32.mem_iq_valid_out, d32.alu_iq_valid_out},
            {d32.branch_iq_ready_in, d32.mem_iq_ready_in, d32.alu_iq_ready_in},
            d32.rob_write_valid_out, d32.iq_payload_out, d32.rob_write_index_out,
            d32.rob_write_payload_out);
    mon_one(1'b1, {d4.branch_iq_valid_out, d4.mem_iq_valid_out, d4.alu_iq_valid_out},
            {d4.branch_iq_ready_in, d4.mem_iq_ready_in, d4.alu_iq_ready_in},
            d4.rob_write_valid_out, d4.iq_payload_out, d4.rob_write_index_out,
            d4.rob_write_payload_out);
    acc32 = d32.rename_valid_in && d32.rename_ready_out && !d32.flush_in;
    acc4  = d4.rename_valid_in && d4.rename_ready_out && !d4.flush_in;
    if (acc32) begin
      e.instr = d32.rename_payload_in; e.rob_index = RobIndex'(tail32);
      q32.push_back(e); tail32++;
    end
    if (acc4) begin
      e.instr = d4.rename_payload_in; e.rob_index = RobIndex'(tail4);
      q4.push_back(e); tail4++;
    end
    if (!rst_n || d32.flush_in) begin q32.delete(); tail32 = 5'd0; end
    if (!rst_n || d4.flush_in)  begin q4.delete();  tail4 = 2'd0;  end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit use4, input RenamedInstruction ins);
    int n = 0;
    if (use4) begin d4.rename_valid_in = 1'b1; d4.rename_payload_in = ins; end
    else begin d32.rename_valid_in = 1'b1; d32.rename_payload_in = ins; end
    do begin step(); n++; end while (!(use4 ? acc4 : acc32) && n < 20);
    check(use4 ? "send_accept4" : "send_accept32", 128'(use4 ? acc4 : acc32), 128'(1));
    if (use4) d4.rename_valid_in = 1'b0; else d32.rename_valid_in = 1'b0;
  endtask

  task automatic drain(input bit use4);
    int n = 0;
    while ((use4 ? q4.size() : q32.size()) != 0 && n < 30) begin step(); n++; end
    check(use4 ? "drain4" : "drain32", 128'(use4 ? q4.size() : q32.size()), 128'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 128'(d32.rename_ready_out), 128'(0));
    check("rst_valids", 128'({d32.alu_iq_valid_out, d32.mem_iq_valid_out,
                              d32.branch_iq_valid_out}), 128'(0));
    check("rst_rob_wr", 128'(d32.rob_write_valid_out), 128'(0));
    check("rst_iq_payload", 128'(d32.iq_payload_out), 128'(0));
    check("rst_rob_index", 128'(d32.rob_write_index_out), 128'(0));
  endtask

  initial begin
    DispatchPayload hold;
    RenamedInstruction m2;

    rst_n = 1'b0;
    d32.rename_valid_in = 1'b1; d32.rename_payload_in = mk(FU_ALU, 99);
    d32.rob_retire_valid_in = 1'b0; d32.flush_in = 1'b0;
    d32.alu_iq_ready_in = 1'b1; d32.mem_iq_ready_in = 1'b1; d32.branch_iq_ready_in = 1'b1;
    d4.rename_valid_in = 1'b0; d4.rename_payload_in = '0;
    d4.rob_retire_valid_in = 1'b0; d4.flush_in = 1'b0;
    d4.alu_iq_ready_in = 1'b1; d4.mem_iq_ready_in = 1'b1; d4.branch_iq_ready_in = 1'b1;

    // Reset with an instruction offered: nothing accepted, outputs at reset values.
    step(); step();
    check_reset_outputs();
    d32.rename_valid_in = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 128'(d32.rename_ready_out), 128'(1));
    check("post_rst_count", 128'(dut.rob_count_r), 128'(0));

    // Three ALU instructions back to back.
    fires32 = 0;
    send(1'b0, mk(FU_ALU, 1));
    check("lat_valid", 128'(d32.alu_iq_valid_out), 128'(1));
    check("lat_index", 128'(d32.iq_payload_out.rob_index), 128'(0));
    send(1'b0, mk(FU_ALU, 2));
    send(1'b0, mk(FU_ALU, 3));
    step();
    check("b2b_fires", 128'(fires32), 128'(3));
    check("b2b_count", 128'(dut.rob_count_r), 128'(3));

    // MEM head stalled by its queue.
    d32.alu_iq_ready_in = 1'b0; d32.mem_iq_ready_in = 1'b0;
    send(1'b0, mk(FU_MEM, 4));
    hold.instr = mk(FU_MEM, 4); hold.rob_index = 5'd3;
    send(1'b0, mk(FU_MEM, 5));
    m2 = mk(FU_MEM, 6);
    d32.rename_valid_in = 1'b1; d32.rename_payload_in = m2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_mem_valid", 128'(d32.mem_iq_valid_out), 128'(1));
      check("stall_payload", 128'(d32.iq_payload_out), 128'(hold));
      check("stall_other_valids", 128'({d32.alu_iq_valid_out, d32.branch_iq_valid_out}), 128'(0));
      check("stall_ready", 128'(d32.rename_ready_out), 128'(0));
    end
    d32.mem_iq_ready_in = 1'b1;
    send(1'b0, m2);
    drain(1'b0);
    check("mem_count", 128'(dut.rob_count_r), 128'(6));

    // Retire down to 3, then fire and retire together.
    d32.rob_retire_valid_in = 1'b1;
    step(); step(); step();
    d32.rob_retire_valid_in = 1'b0;
    check("retire_count", 128'(dut.rob_count_r), 128'(3));
    d32.alu_iq_ready_in = 1'b1;
    send(1'b0, mk(FU_ALU, 7));
    d32.rob_retire_valid_in = 1'b1;
    step();
    d32.rob_retire_valid_in = 1'b0;
    check("fire_retire_count", 128'(dut.rob_count_r), 128'(3));
    check("fire_retire_tail", 128'(dut.rob_tail_r), 128'(7));

    // Build rob_count 7 with two buffered, then flush.
    for (int i = 0; i < 4; i++) send(1'b0, mk(FU_ALU, 8 + i));
    drain(1'b0);
    check("pre_flush_count", 128'(dut.rob_count_r), 128'(7));
    d32.alu_iq_ready_in = 1'b0;
    send(1'b0, mk(FU_ALU, 12));
    send(1'b0, mk(FU_ALU, 13));
    check("pre_flush_full", 128'(d32.rename_ready_out), 128'(0));
    d32.alu_iq_ready_in = 1'b1;
    d32.flush_in = 1'b1;
    #1;
    check("flush_valids", 128'({d32.alu_iq_valid_out, d32.mem_iq_valid_out,
                                d32.branch_iq_valid_out}), 128'(0));
    check("flush_rob_wr", 128'(d32.rob_write_valid_out), 128'(0));
    step();
    d32.flush_in = 1'b0;
    #1;
    check("flush_fifo_empty", 128'(dut.u_fifo.count_r), 128'(0));
    check("flush_count", 128'(dut.rob_count_r), 128'(0));
    check("flush_tail", 128'(dut.rob_tail_r), 128'(0));
    check("flush_ready", 128'(d32.rename_ready_out), 128'(1));
    check("flush_no_valid", 128'(d32.alu_iq_valid_out), 128'(0));

    // Reset while a branch is stalled.
    d32.branch_iq_ready_in = 1'b0;
    send(1'b0, mk(FU_BRANCH, 14));
    check("br_stall_valid", 128'(d32.branch_iq_valid_out), 128'(1));
    rst_n = 1'b0;
    d32.branch_iq_ready_in = 1'b1;
    #1;
    check_reset_outputs();
    step();
    check_reset_outputs();
    rst_n = 1'b1;
    step();
    check("br_discarded", 128'(d32.branch_iq_valid_out), 128'(0));
    send(1'b0, mk(FU_ALU, 15));
    check("post_rst_index", 128'(d32.iq_payload_out.rob_index), 128'(0));
    drain(1'b0);

    // ROB_DEPTH 4: fill, block, retire, wrap.
    for (int i = 0; i < 4; i++) send(1'b1, mk(FU_ALU, 20 + i));
    drain(1'b1);
    check("d4_full_count", 128'(dut4.rob_count_r), 128'(4));
    send(1'b1, mk(FU_ALU, 24));
    step();
    check("d4_full_valids", 128'({d4.alu_iq_valid_out, d4.mem_iq_valid_out,
                                  d4.branch_iq_valid_out}), 128'(0));
    send(1'b1, mk(FU_ALU, 25));
    check("d4_fifo_full", 128'(d4.rename_ready_out), 128'(0));
    d4.rob_retire_valid_in = 1'b1;
    step();
    d4.rob_retire_valid_in = 1'b0;
    check("d4_reenable", 128'(d4.alu_iq_valid_out), 128'(1));
    check("d4_wrap_index", 128'(d4.iq_payload_out.rob_index), 128'(0));
    step();
    check("d4_left", 128'(q4.size()), 128'(1));
    check("d4_count", 128'(dut4.rob_count_r), 128'(4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
